// File: rtl/sram_bank_phase_sequencer.sv
// -----------------------------------------------------------------------------
// sram_bank_phase_sequencer
//
// Two-requester round-robin arbiter plus Bennett-style phase sequencer for the
// adiabatic 2-port SRAM bank. One access is granted at a time, and its address
// and write-enable are latched. The bank's clkpos phases then ramp up one level
// at a time, hold at all-ones, and ramp down in reverse order. clkneg is always
// the bitwise complement of clkpos.
//
// Ports
//   clk        in   1        system clock, all state updates on posedge
//   reset      in   1        synchronous, active-high
//   req0/1     in   1        port request, held high until the matching ack
//   addr0/1    in   ADDR_W   port address, valid with req
//   we0/1      in   1        port write enable, valid with req
//   ack0/1     out  1        1-cycle pulse: port granted, address latched
//   bank_addr  out  ADDR_W   latched address of the current access
//   bank_we    out  1        latched write enable of the current access
//   bank_port  out  1        index of the granted port
//   clkpos     out  PHASES   thermometer phase enables (bit j high iff j < lvl)
//   clkneg     out  PHASES   ~clkpos, same cycle
//   busy       out  1        high whenever the sequencer is not idle
//   done       out  1        1-cycle pulse when ramp-down completes
// -----------------------------------------------------------------------------
module sram_bank_phase_sequencer #(
  parameter int PHASES   = 10,
  parameter int STEP     = 1,
  parameter int HOLD_CYC = 2,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic [ADDR_W-1:0] bank_addr,
  output logic              bank_we,
  output logic              bank_port,
  output logic [PHASES-1:0] clkpos,
  output logic [PHASES-1:0] clkneg,
  output logic              busy,
  output logic              done
);

  localparam int LW   = $clog2(PHASES + 1);
  localparam int CMAX = (STEP > HOLD_CYC) ? STEP : HOLD_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // rr_q = 1 means port 1 wins the next tie.
  logic            rr_q, rr_d;
  logic            grant1;
  logic            ack0_d, ack1_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic            we_d, port_d;

  function automatic logic [PHASES-1:0] therm(input logic [LW-1:0] l);
    logic [PHASES-1:0] t;
    for (int j = 0; j < PHASES; j++) t[j] = (j < int'(l));
    return t;
  endfunction

  // Port 1 wins if it is the sole requester or if both request and it is favoured.
  assign grant1 = req1 & (~req0 | rr_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done_d  = 1'b0;
    addr_d  = bank_addr;
    we_d    = bank_we;
    port_d  = bank_port;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = UP;
          lvl_d   = LW'(1);
          cnt_d   = '0;
          port_d  = grant1;
          addr_d  = grant1 ? addr1 : addr0;
          we_d    = grant1 ? we1 : we0;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          rr_d    = ~grant1;
        end
      end
      UP: begin
        if (cnt_q == CW'(STEP - 1)) begin
          cnt_d = '0;
          // Top level has been held a full STEP: move on to HOLD.
          if (lvl_q == LW'(PHASES)) state_d = HOLD;
          else                      lvl_d   = lvl_q + LW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = DOWN;
          lvl_d   = LW'(PHASES - 1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        if (cnt_q == CW'(STEP - 1)) begin
          cnt_d = '0;
          // Leaving level 1 finishes the access; IDLE can grant on the next edge.
          if (lvl_q == LW'(1)) begin
            state_d = IDLE;
            lvl_d   = '0;
            done_d  = 1'b1;
          end else begin
            lvl_d = lvl_q - LW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bank_addr <= '0;
      bank_we   <= 1'b0;
      bank_port <= 1'b0;
      clkpos    <= '0;
      clkneg    <= '1;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      done      <= done_d;
      busy      <= (state_d != IDLE);
      bank_addr <= addr_d;
      bank_we   <= we_d;
      bank_port <= port_d;
      clkpos    <= therm(lvl_d);
      clkneg    <= ~therm(lvl_d);
    end
  end

endmodule

// File: tb/tb_sram_bank_phase_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for sram_bank_phase_sequencer. Instance dut_a uses the default
// parameters; dut_b uses STEP=2, HOLD_CYC=1 for the slow-ramp timing.
// k counts cycles after the grant edge (k=1 is the ack cycle).
// -----------------------------------------------------------------------------
module tb_sram_bank_phase_sequencer;

  localparam int PH = 10;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          ack0, ack1, bank_we, bank_port, busy, done;
  logic [AW-1:0] bank_addr;
  logic [PH-1:0] clkpos, clkneg;

  logic          reqb = 1'b0;
  logic          ack0_b, ack1_b, bank_we_b, bank_port_b, busy_b, done_b;
  logic [AW-1:0] bank_addr_b;
  logic [PH-1:0] clkpos_b, clkneg_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sram_bank_phase_sequencer #(.PHASES(PH), .STEP(1), .HOLD_CYC(2), .ADDR_W(AW)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0),
    .req1(req1), .addr1(addr1), .we1(we1),
    .ack0(ack0), .ack1(ack1),
    .bank_addr(bank_addr), .bank_we(bank_we), .bank_port(bank_port),
    .clkpos(clkpos), .clkneg(clkneg), .busy(busy), .done(done)
  );

  sram_bank_phase_sequencer #(.PHASES(PH), .STEP(2), .HOLD_CYC(1), .ADDR_W(AW)) dut_b (
    .clk(clk), .reset(reset),
    .req0(reqb), .addr0(6'h07), .we0(1'b0),
    .req1(1'b0), .addr1(6'h00), .we1(1'b0),
    .ack0(ack0_b), .ack1(ack1_b),
    .bank_addr(bank_addr_b), .bank_we(bank_we_b), .bank_port(bank_port_b),
    .clkpos(clkpos_b), .clkneg(clkneg_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic adv(input int target);
    while (k < target) tick();
  endtask

  // Walks n consecutive grants on dut_a starting in an ack cycle. Port sequence
  // is either alternating from `first` or fixed at `first`.
  task automatic run_grants(input int n, input int first, input bit alt);
    int p;
    for (int g = 0; g < n; g++) begin
      p = alt ? ((first + g) % 2) : first;
      check($sformatf("g%0d_ack0", g), ack0, (p == 0));
      check($sformatf("g%0d_ack1", g), ack1, (p == 1));
      check($sformatf("g%0d_port", g), bank_port, p);
      check($sformatf("g%0d_addr", g), bank_addr, (p == 1) ? 32'h11 : 32'h2A);
      check($sformatf("g%0d_lvl1", g), clkpos, 32'h001);
      repeat (21) tick();
      check($sformatf("g%0d_done", g), done, 1);
      check($sformatf("g%0d_done_pos", g), clkpos, 0);
      check($sformatf("g%0d_done_busy", g), busy, 0);
      check($sformatf("g%0d_done_acks", g), {ack0, ack1}, 0);
      check($sformatf("g%0d_done_port", g), bank_port, p);
      tick();
    end
  endtask

  // Per-cycle structural checks on both instances.
  int  prev_a = 0, prev_b = 0;
  bit  prev_rst = 1'b1;
  always @(negedge clk) begin
    int ca, cb, da, db;
    if (mon_en) begin
      ca = $countones(clkpos);
      cb = $countones(clkpos_b);
      check("clkneg_a", clkneg, {22'b0, ~clkpos});
      check("clkneg_b", clkneg_b, {22'b0, ~clkpos_b});
      check("therm_a", clkpos & (clkpos + 10'd1), 0);
      check("therm_b", clkpos_b & (clkpos_b + 10'd1), 0);
      if (!prev_rst) begin
        da = (ca > prev_a) ? ca - prev_a : prev_a - ca;
        db = (cb > prev_b) ? cb - prev_b : prev_b - cb;
        check("lvl_step_a", (da > 1) ? da : 0, 0);
        check("lvl_step_b", (db > 1) ? db : 0, 0);
      end
      prev_a = ca;
      prev_b = cb;
    end
    prev_rst = reset;
  end

  initial begin
    // Reset state.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_clkpos", clkpos, 0);
    check("rst_clkneg", clkneg, 32'h3FF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_addr", bank_addr, 0);
    check("rst_we_port", {bank_we, bank_port}, 0);

    // Test 1: single port-0 write, full ramp at the default timing.
    addr0 = 6'h15; we0 = 1'b1; req0 = 1'b1;
    k = 0;
    tick();
    check("t1_ack0", ack0, 1);
    check("t1_pos1", clkpos, 32'h001);
    check("t1_busy", busy, 1);
    check("t1_addr", bank_addr, 32'h15);
    check("t1_we", bank_we, 1);
    req0 = 1'b0; addr0 = 6'h3F; we0 = 1'b0;
    adv(2);  check("t1_ack_pulse", ack0, 0);
             check("t1_pos2", clkpos, 32'h003);
    adv(10); check("t1_pos10", clkpos, 32'h3FF);
    adv(11); check("t1_pos11", clkpos, 32'h3FF);
    adv(12); check("t1_pos12", clkpos, 32'h3FF);
    adv(13); check("t1_pos13", clkpos, 32'h1FF);
             check("t1_addr_held", bank_addr, 32'h15);
    adv(21); check("t1_pos21", clkpos, 32'h001);
             check("t1_done_early", done, 0);
    adv(22); check("t1_pos22", clkpos, 0);
             check("t1_done", done, 1);
             check("t1_busy_end", busy, 0);
             check("t1_addr_end", bank_addr, 32'h15);
             check("t1_we_end", bank_we, 1);
    adv(23); check("t1_done_pulse", done, 0);
             check("t1_idle", clkpos, 0);

    // Test 2: both ports held from reset release, grants alternate 0,1,0,1.
    addr0 = 6'h2A; we0 = 1'b0; addr1 = 6'h11; we1 = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    k = 0;
    tick();
    run_grants(4, 0, 1'b1);

    // Test 3: port 1 alone, held; back-to-back grants with no gap cycle.
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    req1 = 1'b1;
    k = 0;
    tick();
    run_grants(3, 1, 1'b0);

    // Test 4: reset mid-ramp, then a tie goes to port 0 again.
    req1 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1;
    k = 0;
    tick();
    check("t4_ack0", ack0, 1);
    req0 = 1'b0;
    adv(5);
    check("t4_pos5", clkpos, 32'h01F);
    req0 = 1'b1; req1 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_rst_pos", clkpos, 0);
    check("t4_rst_neg", clkneg, 32'h3FF);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_acks", {ack0, ack1}, 0);
    tick();
    check("t4_tie_ack0", ack0, 1);
    check("t4_tie_ack1", ack1, 0);
    check("t4_tie_port", bank_port, 0);
    req0 = 1'b0; req1 = 1'b0;

    // Test 5: STEP=2, HOLD_CYC=1 instance, 40-cycle period.
    reqb = 1'b1;
    k = 0;
    tick();
    check("t5_ack", ack0_b, 1);
    check("t5_pos1", clkpos_b, 32'h001);
    adv(2);  check("t5_pos2", clkpos_b, 32'h001);
             check("t5_ack_pulse", ack0_b, 0);
    adv(3);  check("t5_pos3", clkpos_b, 32'h003);
    adv(18); check("t5_pos18", clkpos_b, 32'h1FF);
    adv(19); check("t5_pos19", clkpos_b, 32'h3FF);
    adv(21); check("t5_pos21", clkpos_b, 32'h3FF);
    adv(22); check("t5_pos22", clkpos_b, 32'h1FF);
    adv(23); check("t5_pos23", clkpos_b, 32'h1FF);
    adv(39); check("t5_pos39", clkpos_b, 32'h001);
             check("t5_done_early", done_b, 0);
    adv(40); check("t5_pos40", clkpos_b, 0);
             check("t5_done", done_b, 1);
             check("t5_addr", bank_addr_b, 32'h07);
    adv(41); check("t5_reack", ack0_b, 1);
             check("t5_pos41", clkpos_b, 32'h001);
    reqb = 1'b0;
    adv(45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
